// File: rtl/dma_pkg.sv
// Shared DMA command/state types.
// The CPU decoder uses dma_cmd_t to issue transfers.
package dma_pkg;

  typedef enum logic [1:0] {
    DMA_NONE = 2'b00,
    DMA_D2S  = 2'b01,
    DMA_S2D  = 2'b10
  } dma_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_D2S_REQ,
    ST_D2S_WR,
    ST_S2D_RD,
    ST_S2D_WAIT,
    ST_S2D_REQ,
    ST_DONE
  } dma_state_t;

  // 2'b11 and zero-length requests start nothing
  function automatic logic cmd_valid(
    input logic [1:0] cmd,
    input logic [9:0] width
  );
    return ((cmd == DMA_D2S) || (cmd == DMA_S2D))
        && (width != 10'd0);
  endfunction

endpackage

// File: rtl/dma_sram_mux.sv
// SRAM port arbitration between the CPU data side
// and the DMA engine.
module dma_sram_mux (
  input  logic        dma_owns_sram,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  input  logic        dma_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic        sram_we
);

  assign sram_addr  = dma_owns_sram ? dma_addr  : cpu_addr;
  assign sram_wdata = dma_owns_sram ? dma_wdata : cpu_wdata;
  assign sram_we    = dma_owns_sram ? dma_we    : cpu_we;

endmodule

// File: rtl/dma_ctrl.sv
// DRAM<->SRAM word-copy engine that stalls the CPU
// from the command cycle until the one-cycle DONE.
module dma_ctrl
  import dma_pkg::*;
#(
  parameter int SRAM_AW = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  dmaCmd,
  input  logic [31:0] dmaSrcAddress,
  input  logic [31:0] dmaDstAddress,
  input  logic [9:0]  dmaWidth,
  output logic        stall,
  input  logic [31:0] cpuSramAddress,
  input  logic [31:0] cpuSramWriteData,
  input  logic        cpuSramWriteEnable,
  output logic [31:0] sramAddress,
  output logic [31:0] sramWriteData,
  output logic        sramWriteEnable,
  input  logic [31:0] sramReadData,
  output logic        dramReq,
  output logic        dramWe,
  output logic [31:0] dramAddress,
  output logic [31:0] dramWriteData,
  input  logic        dramAck,
  input  logic [31:0] dramReadData
);

  localparam logic [31:0] SRAM_MASK =
    ((32'd1 << (SRAM_AW + 2)) - 32'd1) & ~32'd3;

  dma_state_t  state_q, state_d;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] data_q, data_d;
  logic [9:0]  rem_q, rem_d;

  logic        cmd_ok;
  logic        dma_owns_sram;
  logic        s2d_phase;
  logic        dma_sram_we;
  logic [31:0] dma_sram_addr;
  logic        unused_addr_bits;

  assign cmd_ok = cmd_valid(dmaCmd, dmaWidth);
  assign unused_addr_bits =
    ^{dmaSrcAddress[1:0], dmaDstAddress[1:0]};

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    data_d  = data_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_ok) begin
          src_d   = {dmaSrcAddress[31:2], 2'b00};
          dst_d   = {dmaDstAddress[31:2], 2'b00};
          rem_d   = dmaWidth;
          state_d = (dmaCmd == DMA_D2S) ? ST_D2S_REQ
                                        : ST_S2D_RD;
        end
      end
      ST_D2S_REQ: begin
        if (dramAck) begin
          data_d  = dramReadData;
          state_d = ST_D2S_WR;
        end
      end
      ST_D2S_WR: begin
        src_d   = src_q + 32'd4;
        dst_d   = dst_q + 32'd4;
        rem_d   = rem_q - 10'd1;
        state_d = (rem_q != 10'd1) ? ST_D2S_REQ : ST_DONE;
      end
      ST_S2D_RD: begin
        state_d = ST_S2D_WAIT;
      end
      ST_S2D_WAIT: begin
        data_d  = sramReadData;
        state_d = ST_S2D_REQ;
      end
      ST_S2D_REQ: begin
        if (dramAck) begin
          src_d   = src_q + 32'd4;
          dst_d   = dst_q + 32'd4;
          rem_d   = rem_q - 10'd1;
          state_d = (rem_q != 10'd1) ? ST_S2D_RD : ST_DONE;
        end
      end
      // DONE ignores dmaCmd so a held instruction cannot re-fire
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
    end
  end

  assign dma_owns_sram = (state_q != ST_IDLE)
                      && (state_q != ST_DONE);

  assign stall = dma_owns_sram
              || ((state_q == ST_IDLE) && cmd_ok);

  assign s2d_phase = (state_q == ST_S2D_RD)
                  || (state_q == ST_S2D_WAIT)
                  || (state_q == ST_S2D_REQ);

  assign dma_sram_we   = (state_q == ST_D2S_WR);
  assign dma_sram_addr = (s2d_phase ? src_q : dst_q)
                       & SRAM_MASK;

  assign dramReq = (state_q == ST_D2S_REQ)
                || (state_q == ST_S2D_REQ);
  assign dramWe  = (state_q == ST_S2D_REQ);
  assign dramAddress   = (state_q == ST_S2D_REQ) ? dst_q
                                                 : src_q;
  assign dramWriteData = data_q;

  dma_sram_mux u_sram_mux (
    .dma_owns_sram (dma_owns_sram),
    .cpu_addr      (cpuSramAddress),
    .cpu_wdata     (cpuSramWriteData),
    .cpu_we        (cpuSramWriteEnable),
    .dma_addr      (dma_sram_addr),
    .dma_wdata     (data_q),
    .dma_we        (dma_sram_we),
    .sram_addr     (sramAddress),
    .sram_wdata    (sramWriteData),
    .sram_we       (sramWriteEnable)
  );

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl with behavioural SRAM
// and a variable-latency DRAM responder.
module tb_dma_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  dmaCmd;
  logic [31:0] dmaSrcAddress;
  logic [31:0] dmaDstAddress;
  logic [9:0]  dmaWidth;
  logic        stall;
  logic [31:0] cpuSramAddress;
  logic [31:0] cpuSramWriteData;
  logic        cpuSramWriteEnable;
  logic [31:0] sramAddress;
  logic [31:0] sramWriteData;
  logic        sramWriteEnable;
  logic [31:0] sramReadData = 32'd0;
  logic        dramReq;
  logic        dramWe;
  logic [31:0] dramAddress;
  logic [31:0] dramWriteData;
  logic        dramAck = 1'b0;
  logic [31:0] dramReadData = 32'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dma_ctrl #(.SRAM_AW(14)) dut (
    .clk                (clk),
    .reset              (reset),
    .dmaCmd             (dmaCmd),
    .dmaSrcAddress      (dmaSrcAddress),
    .dmaDstAddress      (dmaDstAddress),
    .dmaWidth           (dmaWidth),
    .stall              (stall),
    .cpuSramAddress     (cpuSramAddress),
    .cpuSramWriteData   (cpuSramWriteData),
    .cpuSramWriteEnable (cpuSramWriteEnable),
    .sramAddress        (sramAddress),
    .sramWriteData      (sramWriteData),
    .sramWriteEnable    (sramWriteEnable),
    .sramReadData       (sramReadData),
    .dramReq            (dramReq),
    .dramWe             (dramWe),
    .dramAddress        (dramAddress),
    .dramWriteData      (dramWriteData),
    .dramAck            (dramAck),
    .dramReadData       (dramReadData)
  );

  // SRAM: synchronous write, read data one cycle later
  logic [31:0] sram_mem [0:255];
  int sram_wr_cnt = 0;

  always @(posedge clk) begin
    if (sramWriteEnable) begin
      sram_mem[sramAddress[9:2]] <= sramWriteData;
      sram_wr_cnt <= sram_wr_cnt + 1;
    end
    sramReadData <= sram_mem[sramAddress[9:2]];
  end

  // DRAM: ack in the ack_lat-th cycle of a held request
  int ack_lat = 2;
  int dcnt = 0;
  int rd_acks = 0;
  int wr_acks = 0;
  logic [31:0] dram_wr_mem [0:255];

  function automatic logic [31:0] dram_pattern(
    input logic [7:0] w
  );
    case (w)
      8'd64:   return 32'h0000_000A;
      8'd65:   return 32'h0000_000B;
      8'd66:   return 32'h0000_000C;
      8'd67:   return 32'h0000_000D;
      8'd192:  return 32'h0000_0051;
      8'd193:  return 32'h0000_0052;
      8'd194:  return 32'h0000_0053;
      8'd195:  return 32'h0000_0054;
      default: return 32'hDEAD_0000 | {24'd0, w};
    endcase
  endfunction

  always @(negedge clk) begin
    if (dramReq) begin
      dcnt = dcnt + 1;
      if (dcnt >= ack_lat) begin
        dcnt = 0;
        dramAck = 1'b1;
        dramReadData = dram_pattern(dramAddress[9:2]);
        if (dramWe) begin
          dram_wr_mem[dramAddress[9:2]] = dramWriteData;
          wr_acks = wr_acks + 1;
        end else begin
          rd_acks = rd_acks + 1;
        end
      end else begin
        dramAck = 1'b0;
      end
    end else begin
      dcnt = 0;
      dramAck = 1'b0;
    end
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(
    input logic [31:0] a,
    input logic [31:0] d
  );
    cpuSramWriteEnable = 1'b1;
    cpuSramAddress     = a;
    cpuSramWriteData   = d;
    tick();
    cpuSramWriteEnable = 1'b0;
  endtask

  task automatic count_stall(output int n);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (stall !== 1'b1) break;
      n++;
      tick();
    end
  endtask

  int n;
  int s_cnt;
  int r_cnt;
  int base_sw;
  int base_rd;

  initial begin
    reset              = 1'b0;
    dmaCmd             = 2'b00;
    dmaSrcAddress      = 32'd0;
    dmaDstAddress      = 32'd0;
    dmaWidth           = 10'd0;
    cpuSramAddress     = 32'd0;
    cpuSramWriteData   = 32'd0;
    cpuSramWriteEnable = 1'b0;
    repeat (3) tick();
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_dram_req", {31'd0, dramReq}, 32'd0);
    chk("rst_dram_we", {31'd0, dramWe}, 32'd0);
    chk("rst_sram_we", {31'd0, sramWriteEnable}, 32'd0);
    reset = 1'b1;
    tick();

    // CPU owns SRAM in IDLE
    cpuSramWriteEnable = 1'b1;
    cpuSramAddress     = 32'h54;
    cpuSramWriteData   = 32'd7;
    #1;
    chk("idle_mux_we", {31'd0, sramWriteEnable}, 32'd1);
    chk("idle_mux_addr", sramAddress, 32'h54);
    tick();
    cpuSramWriteEnable = 1'b0;
    chk("cpu_word21", sram_mem[21], 32'd7);
    cpu_write(32'h10, 32'h11);
    cpu_write(32'h14, 32'h22);
    cpu_write(32'h58, 32'h33);
    cpu_write(32'h84, 32'hEE);

    // d2s, 3 words, ack latency 2; cmd held into DONE
    dmaCmd        = 2'b01;
    dmaSrcAddress = 32'h100;
    dmaDstAddress = 32'h40;
    dmaWidth      = 10'd3;
    #1;
    chk("d2s_cmd_stall", {31'd0, stall}, 32'd1);
    chk("d2s_cmd_noreq", {31'd0, dramReq}, 32'd0);
    tick();
    chk("d2s_req", {31'd0, dramReq}, 32'd1);
    chk("d2s_req_we", {31'd0, dramWe}, 32'd0);
    chk("d2s_req_addr", dramAddress, 32'h100);
    cpuSramWriteEnable = 1'b1;
    cpuSramAddress     = 32'h58;
    cpuSramWriteData   = 32'd9;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      if (stall !== 1'b1) break;
      n++;
      if (n == 4) cpuSramWriteEnable = 1'b0;
      tick();
    end
    chk("d2s_stall_cycles", n, 32'd9);
    chk("done_mux_addr", sramAddress, 32'h58);
    chk("d2s_rd_acks", rd_acks, 32'd3);
    tick();
    dmaCmd = 2'b00;
    #1;
    chk("done_no_retrig_stall", {31'd0, stall}, 32'd0);
    chk("done_no_retrig_req", {31'd0, dramReq}, 32'd0);
    tick();
    chk("d2s_word16", sram_mem[16], 32'hA);
    chk("d2s_word17", sram_mem[17], 32'hB);
    chk("d2s_word18", sram_mem[18], 32'hC);
    chk("cpu_blocked_word22", sram_mem[22], 32'h33);
    chk("d2s_one_transfer", rd_acks, 32'd3);

    // re-arm with one word, low address bits set
    dmaCmd        = 2'b01;
    dmaSrcAddress = 32'h10F;
    dmaDstAddress = 32'h4E;
    dmaWidth      = 10'd1;
    #1;
    chk("rearm_stall", {31'd0, stall}, 32'd1);
    tick();
    dmaCmd = 2'b00;
    count_stall(n);
    chk("w1_stall_cycles", n, 32'd3);
    tick();
    chk("w1_word19", sram_mem[19], 32'hD);

    // s2d, 2 words, ack latency 3
    ack_lat = 3;
    base_sw = sram_wr_cnt;
    base_rd = rd_acks;
    dmaCmd        = 2'b10;
    dmaSrcAddress = 32'h10;
    dmaDstAddress = 32'h200;
    dmaWidth      = 10'd2;
    #1;
    chk("s2d_cmd_stall", {31'd0, stall}, 32'd1);
    tick();
    dmaCmd = 2'b00;
    count_stall(n);
    chk("s2d_stall_cycles", n, 32'd10);
    tick();
    chk("s2d_wr_acks", wr_acks, 32'd2);
    chk("s2d_dram_200", dram_wr_mem[128], 32'h11);
    chk("s2d_dram_204", dram_wr_mem[129], 32'h22);
    chk("s2d_no_sram_wr", sram_wr_cnt, base_sw);
    chk("s2d_no_reads", rd_acks, base_rd);

    // zero width and reserved command start nothing
    ack_lat       = 2;
    dmaCmd        = 2'b01;
    dmaSrcAddress = 32'h100;
    dmaDstAddress = 32'h40;
    dmaWidth      = 10'd0;
    #1;
    chk("w0_cmd_stall", {31'd0, stall}, 32'd0);
    s_cnt = 0;
    r_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (stall) s_cnt++;
      if (dramReq) r_cnt++;
    end
    chk("w0_stall_seen", s_cnt, 32'd0);
    chk("w0_req_seen", r_cnt, 32'd0);
    dmaCmd   = 2'b11;
    dmaWidth = 10'd5;
    #1;
    chk("cmd11_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("cmd11_req", {31'd0, dramReq}, 32'd0);
    dmaCmd = 2'b00;
    tick();

    // reset in the second D2S_REQ of a 4-word copy
    base_sw       = sram_wr_cnt;
    dmaCmd        = 2'b01;
    dmaSrcAddress = 32'h300;
    dmaDstAddress = 32'h80;
    dmaWidth      = 10'd4;
    #1;
    tick();
    dmaCmd = 2'b00;
    for (int i = 0; i < 50; i++) begin
      if (sram_wr_cnt != base_sw) break;
      tick();
    end
    chk("mid_first_word", sram_wr_cnt - base_sw, 32'd1);
    chk("mid_in_req2", {31'd0, dramReq}, 32'd1);
    reset = 1'b0;
    tick();
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_req", {31'd0, dramReq}, 32'd0);
    chk("abort_sram_we", {31'd0, sramWriteEnable}, 32'd0);
    reset = 1'b1;
    repeat (6) tick();
    chk("abort_wr_count", sram_wr_cnt - base_sw, 32'd1);
    chk("abort_word32", sram_mem[32], 32'h51);
    chk("abort_word33", sram_mem[33], 32'hEE);
    chk("abort_idle_req", {31'd0, dramReq}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dma_ctrl.md
DMA_CTRL -- requirements
Module: dma_ctrl

Interface
REQ-001 Parameter SRAM_AW, default 14, SRAM word-address width; sramAddress[SRAM_AW+1:2] is the SRAM word index.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 dmaCmd  input  2  00 none, 01 d2s (DRAM->SRAM), 10 s2d (SRAM->DRAM), 11 reserved (treated as 00).
REQ-005 dmaSrcAddress, dmaDstAddress  input  32 each  byte addresses; bits [1:0] ignored.
REQ-006 dmaWidth  input  10  transfer length in 32-bit words.
REQ-007 stall  output  1  freezes the CPU pipeline while a transfer is pending or active.
REQ-008 cpuSramAddress, cpuSramWriteData  input  32 each; cpuSramWriteEnable  input  1  CPU data-side SRAM request.
REQ-009 sramAddress, sramWriteData  output  32 each; sramWriteEnable  output  1  muxed SRAM port.
REQ-010 sramReadData  input  32  SRAM read data, valid the cycle after the address is presented.
REQ-011 dramReq, dramWe  output  1 each; dramAddress, dramWriteData  output  32 each  DRAM request.
REQ-012 dramAck  input  1; dramReadData  input  32  one-cycle ack, variable latency; read data valid with ack.

Function
REQ-013 States: IDLE, D2S_REQ, D2S_WR, S2D_RD, S2D_WAIT, S2D_REQ, DONE.
REQ-014 IDLE: dmaCmd in {01,10} with dmaWidth!=0 latches src, dst, width and moves to D2S_REQ or S2D_RD; dmaWidth==0 or cmd 00/11 stays IDLE with no stall.
REQ-015 stall = (state not in {IDLE, DONE}) OR (state==IDLE AND a valid command per REQ-014 is present); combinational, so the CPU freezes in the command cycle itself.
REQ-016 D2S_REQ: dramReq=1, dramWe=0, dramAddress=cur_src; held stable until dramAck; on ack, dramReadData is captured and the FSM moves to D2S_WR.
REQ-017 D2S_WR: sramWriteEnable=1, sramAddress=cur_dst, sramWriteData=captured word; src and dst +4, remaining -1; next D2S_REQ if remaining>0, else DONE.
REQ-018 S2D_RD: sramAddress=cur_src, sramWriteEnable=0; next S2D_WAIT, which captures sramReadData and moves to S2D_REQ.
REQ-019 S2D_REQ: dramReq=1, dramWe=1, dramAddress=cur_dst, dramWriteData=captured word; on dramAck, src/dst +4, remaining -1; next S2D_RD if remaining>0, else DONE.
REQ-020 DONE lasts exactly one cycle with stall=0, so the CPU advances; dmaCmd is ignored in DONE and the FSM returns to IDLE, preventing re-trigger by the held instruction.
REQ-021 SRAM mux: in IDLE and DONE the sram* outputs mirror the cpuSram* inputs; in all other states the DMA drives them and sramWriteEnable follows REQ-017 only.
REQ-022 Address arithmetic is 32-bit modulo 2^32 and wraps silently; remaining is 10-bit, so the maximum transfer is 1023 words.
REQ-023 dramAck outside D2S_REQ/S2D_REQ is ignored; dramReq is never asserted in any other state.
REQ-024 Latency per word: d2s = ack_latency+1 cycles; s2d = 2+ack_latency cycles; plus 1 DONE cycle per command.

Reset
REQ-025 Reset low at a rising edge forces IDLE, clears latched addresses, remaining, and captured data, and deasserts dramReq, dramWe, sramWriteEnable, and stall (stall remains subject to REQ-015 in IDLE).
REQ-026 Reset mid-transfer aborts the transfer without completing the current word, and no further SRAM/DRAM writes are issued.

Structure
REQ-027 Package dma_pkg holds the dma_cmd_t enum (DMA_NONE=2'b00, DMA_D2S=2'b01, DMA_S2D=2'b10) and the dma_state_t enum; the CPU shares dma_cmd_t.
REQ-028 The SRAM port multiplexer is one sub-module, dma_sram_mux, selected by a dma_owns_sram signal from the FSM.

Verification
REQ-029 d2s src=0x100, dst=0x40, width=3, DRAM returns 0xA,0xB,0xC with ack after 2 cycles -> SRAM words 16,17,18 = A,B,C; stall high for 9 cycles, then a single low DONE cycle.
REQ-030 s2d with SRAM words 4,5 = 0x11,0x22, src=0x10, dst=0x200, width=2 -> DRAM writes 0x11@0x200 and 0x22@0x204, dramWe=1 on both, no SRAM writes.
REQ-031 width=0 with cmd=01 -> stall never high, no dramReq, FSM remains IDLE.
REQ-032 cmd held at 01 through DONE -> exactly one transfer, and IDLE re-arms only on the next command cycle.
REQ-033 reset low during the second D2S_REQ of width=4 -> next cycle IDLE, stall low, SRAM holds only word 0.
REQ-034 In IDLE, cpuSramWriteEnable=1, addr=0x54, data=7 -> SRAM word 21 = 7; the same request during a transfer is not forwarded.
